// File: rtl/sha3_theta_stage.sv
// ----------------------------------------------------------------------------
// sha3_theta_stage
//   Keccak theta step over one 25-lane state (lane index = x + 5*y):
//     C[x]         = XOR over y of A[x,y]
//     D[x]         = C[x-1] ^ rol1(C[x+1])         (x mod 5)
//     A'[x,y]      = A[x,y] ^ D[x]
//   A per-transaction bypass passes the state through unchanged.
//   LATENCY=2: stage 1 registers lanes + column parities, stage 2 registers
//   the result. LATENCY=1: one register stage holding the final result.
//   Each stage loads when it is empty or its downstream stage is taking data.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   istate   in   25*LANE_WIDTH input state, lane i at [i*W +: W]
//   ibypass  in   1 = pass transaction through without theta
//   ivalid   in   input valid
//   iready   out  stage can accept (transfer on ivalid && iready)
//   ostate   out  25*LANE_WIDTH output state, same lane layout
//   ovalid   out  output valid
//   oready   in   downstream accepts (transfer on ovalid && oready)
// ----------------------------------------------------------------------------
module sha3_theta_stage #(
    parameter     STYLE      = "basic",
    parameter int LANE_WIDTH = 64,
    parameter int LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [25*LANE_WIDTH-1:0]  istate,
    input  logic                      ibypass,
    input  logic                      ivalid,
    output logic                      iready,
    output logic [25*LANE_WIDTH-1:0]  ostate,
    output logic                      ovalid,
    input  logic                      oready
);

    localparam int W  = LANE_WIDTH;
    localparam int SW = 25 * W;

    typedef logic [4:0][W-1:0] cols_t;

    // ---------------- parameter checks ----------------
    if (STYLE != "basic") begin : g_bad_style
        $error("sha3_theta_stage: STYLE must be \"basic\"");
    end
    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_width
        $error("sha3_theta_stage: LANE_WIDTH must be 1,2,4,8,16,32 or 64");
    end

    // ---------------- theta arithmetic ----------------
    // Shift form keeps W=1 legal: v<<1 drops the only bit, v>>0 restores it.
    function automatic logic [W-1:0] rol1(input logic [W-1:0] v);
        return (v << 1) | (v >> (W - 1));
    endfunction

    function automatic cols_t col_parity(input logic [SW-1:0] s);
        cols_t c;
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++)
                c[x] = c[x] ^ s[(x + 5*y)*W +: W];
        end
        return c;
    endfunction

    function automatic logic [SW-1:0] apply_theta(input logic [SW-1:0] s, input cols_t c);
        logic [SW-1:0] r;
        cols_t         d;
        for (int x = 0; x < 5; x++)
            d[x] = c[(x + 4) % 5] ^ rol1(c[(x + 1) % 5]);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[(x + 5*y)*W +: W] = s[(x + 5*y)*W +: W] ^ d[x];
        return r;
    endfunction

    // ---------------- pipeline ----------------
    if (LATENCY == 1) begin : g_lat1
        logic          r_vld;
        logic [SW-1:0] r_state;
        logic          w_ld;

        assign w_ld = !r_vld || oready;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld   <= 1'b0;
                r_state <= '0;
            end else if (w_ld) begin
                r_vld <= ivalid;
                if (ivalid)
                    r_state <= ibypass ? istate : apply_theta(istate, col_parity(istate));
            end
        end

        assign iready = w_ld;
        assign ovalid = r_vld;
        assign ostate = r_state;
    end else if (LATENCY == 2) begin : g_lat2
        logic [2:1]    r_vld_pipe;
        logic [SW-1:0] r_s1_state;
        cols_t         r_s1_c;
        logic          r_s1_byp;
        logic [SW-1:0] r_s2_state;
        logic          w_ld1;
        logic          w_ld2;

        // Stage 1 may load whenever stage 2 is loading, so the ready chain
        // from oready to iready is combinational.
        assign w_ld2 = !r_vld_pipe[2] || oready;
        assign w_ld1 = !r_vld_pipe[1] || w_ld2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld_pipe <= '0;
                r_s1_state <= '0;
                r_s1_c     <= '0;
                r_s1_byp   <= 1'b0;
                r_s2_state <= '0;
            end else begin
                if (w_ld1) begin
                    r_vld_pipe[1] <= ivalid;
                    if (ivalid) begin
                        r_s1_state <= istate;
                        r_s1_c     <= col_parity(istate);
                        r_s1_byp   <= ibypass;
                    end
                end
                if (w_ld2) begin
                    r_vld_pipe[2] <= r_vld_pipe[1];
                    if (r_vld_pipe[1])
                        r_s2_state <= r_s1_byp ? r_s1_state : apply_theta(r_s1_state, r_s1_c);
                end
            end
        end

        assign iready = w_ld1;
        assign ovalid = r_vld_pipe[2];
        assign ostate = r_s2_state;
    end else begin : g_bad_latency
        $error("sha3_theta_stage: LATENCY must be 1 or 2");
    end

endmodule

// File: tb/tb_sha3_theta_stage.sv
module tb_sha3_theta_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT: W=64, LATENCY=2
    logic          rst;
    logic [1599:0] istate;
    logic          ibypass, ivalid, iready, ovalid, oready;
    logic [1599:0] ostate;

    sha3_theta_stage #(.STYLE("basic"), .LANE_WIDTH(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .istate(istate), .ibypass(ibypass), .ivalid(ivalid),
        .iready(iready), .ostate(ostate), .ovalid(ovalid), .oready(oready));

    // second DUT: W=8, LATENCY=1
    logic [199:0] s8_istate, s8_ostate;
    logic         s8_byp, s8_ivalid, s8_iready, s8_ovalid, s8_oready;

    sha3_theta_stage #(.STYLE("basic"), .LANE_WIDTH(8), .LATENCY(1)) dut8 (
        .clk(clk), .rst(rst), .istate(s8_istate), .ibypass(s8_byp), .ivalid(s8_ivalid),
        .iready(s8_iready), .ostate(s8_ostate), .ovalid(s8_ovalid), .oready(s8_oready));

    int total = 0;
    int bad   = 0;
    int npush = 0;
    int npop  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic [1599:0] act, input logic [1599:0] exp, input int w);
        logic [63:0] mask, a, e;
        total++;
        if (act !== exp) begin
            bad++;
            mask = (64'h1 << w) - 64'h1;
            for (int i = 0; i < 25; i++) begin
                a = 64'(act >> (i*w)) & mask;
                e = 64'(exp >> (i*w)) & mask;
                if (a !== e) begin
                    $display("FAIL %s lane=%0d got=%h want=%h", nm, i, a, e);
                    break;
                end
            end
        end
    endtask

    // Bit-level Keccak theta: A'[x][y][z] = A[x][y][z] ^ P[x-1][z] ^ P[x+1][z-1]
    function automatic logic [1599:0] theta_ref(input logic [1599:0] s, input logic byp, input int w);
        logic [1599:0] r;
        logic p1, p2;
        r = '0;
        if (byp) return s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < w; z++) begin
                    p1 = 1'b0;
                    p2 = 1'b0;
                    for (int yy = 0; yy < 5; yy++) begin
                        p1 ^= s[((x + 4) % 5 + 5*yy)*w + z];
                        p2 ^= s[((x + 1) % 5 + 5*yy)*w + (z + w - 1) % w];
                    end
                    r[(x + 5*y)*w + z] = s[(x + 5*y)*w + z] ^ p1 ^ p2;
                end
        return r;
    endfunction

    function automatic logic [1599:0] rnd_state(input int w);
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
        r &= (1600'b1 << (25*w)) - 1600'b1;
        return r;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [1599:0] exp_q[$];
    logic [1599:0] sb_exp;
    logic [1599:0] prev_ost;
    logic          prev_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(ovalid), 64'h1);
                chk_state("hold_data", ostate, prev_ost, 64);
            end
            if (ovalid && oready) begin
                npop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output got=extra want=none");
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk_state("scoreboard", ostate, sb_exp, 64);
                end
            end
            if (ivalid && iready) begin
                exp_q.push_back(theta_ref(istate, ibypass, 64));
                npush++;
            end
            prev_hold = ovalid && !oready;
            prev_ost  = ostate;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [1599:0] s, input logic b);
        int n;
        n       = 0;
        istate  = s;
        ibypass = b;
        ivalid  = 1'b1;
        @(negedge clk);
        while (!iready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!iready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=iready0 want=iready1");
        end
        @(posedge clk); #1;
        ivalid = 1'b0;
    endtask

    // called just after the transfer edge; returns edges until ovalid
    task automatic wait_out(output int cnt);
        cnt = 1;
        while (!ovalid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1599:0] zero = '0;
    logic [1599:0] v, x_exp;
    logic [1599:0] st [4];
    int            cnt, idx;
    int            l1[5] = '{1, 6, 11, 16, 21};
    int            l4[5] = '{4, 9, 14, 19, 24};

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; istate = '0; ibypass = 1'b0; ivalid = 1'b0; oready = 1'b1;
        s8_istate = '0; s8_byp = 1'b0; s8_ivalid = 1'b0; s8_oready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_ovalid", 64'(ovalid), 64'h0);
        chk("rst_iready", 64'(iready), 64'h1);
        chk_state("rst_ostate", ostate, zero, 64);
        chk("rst8_ovalid", 64'(s8_ovalid), 64'h0);

        // all-zero state, latency
        send(zero, 1'b0);
        wait_out(cnt);
        chk("latency_zero", 64'(cnt), 64'd2);
        chk_state("zero_out", ostate, zero, 64);
        idle(2);

        // single bit in lane 0, W=64
        v = '0; v[0] = 1'b1;
        x_exp = '0;
        x_exp[0 +: 64] = 64'h1;
        foreach (l1[i]) x_exp[l1[i]*64 +: 64] = 64'h1;
        foreach (l4[i]) x_exp[l4[i]*64 +: 64] = 64'h2;
        chk_state("model_pin_w64", theta_ref(v, 1'b0, 64), x_exp, 64);
        send(v, 1'b0);
        wait_out(cnt);
        chk("latency_lane0", 64'(cnt), 64'd2);
        chk_state("lane0_w64", ostate, x_exp, 64);
        idle(2);

        // W=8, LATENCY=1: MSB of lane 0 wraps to bit 0 via rol1
        x_exp = '0;
        x_exp[0 +: 8] = 8'h80;
        foreach (l1[i]) x_exp[l1[i]*8 +: 8] = 8'h80;
        foreach (l4[i]) x_exp[l4[i]*8 +: 8] = 8'h01;
        v = '0; v[7] = 1'b1;
        chk_state("model_pin_w8", theta_ref(v, 1'b0, 8), x_exp, 8);
        s8_istate = v[199:0]; s8_byp = 1'b0; s8_ivalid = 1'b1;
        @(negedge clk);
        chk("w8_iready", 64'(s8_iready), 64'h1);
        @(posedge clk); #1;
        // back-to-back bypass transaction follows immediately
        v = rnd_state(8);
        s8_istate = v[199:0]; s8_byp = 1'b1;
        chk("w8_latency", 64'(s8_ovalid), 64'h1);
        chk_state("w8_wrap", {1400'b0, s8_ostate}, x_exp, 8);
        @(posedge clk); #1;
        s8_ivalid = 1'b0;
        chk("w8_valid2", 64'(s8_ovalid), 64'h1);
        chk_state("w8_bypass", {1400'b0, s8_ostate}, v, 8);
        @(posedge clk); #1;
        chk("w8_drained", 64'(s8_ovalid), 64'h0);

        // interleaved bypass/theta, back-to-back
        for (int i = 0; i < 12; i++) send(rnd_state(64), 1'(i % 2));
        idle(4);

        // random backpressure with mixed traffic
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    oready = 1'($urandom % 2);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int i = 0; i < 10; i++) send(rnd_state(64), 1'($urandom % 2));
            end
        join
        oready = 1'b1;
        idle(4);

        // full backpressure: capacity 2, then iready low
        for (int i = 0; i < 4; i++) st[i] = rnd_state(64);
        oready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            istate = st[idx]; ibypass = 1'b0; ivalid = (idx < 4);
            @(negedge clk);
            if (ivalid && iready) idx++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        @(negedge clk);
        chk("bp_iready_low", 64'(iready), 64'h0);
        chk("bp_ovalid", 64'(ovalid), 64'h1);
        @(posedge clk); #1;
        oready = 1'b1;
        while (idx < 4) begin
            send(st[idx], 1'b0);
            idx++;
        end
        idle(5);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("push_pop", 64'(npop), 64'(npush));

        // reset with transactions in flight
        oready = 1'b0;
        send(rnd_state(64), 1'b0);
        send(rnd_state(64), 1'b1);
        istate = rnd_state(64); ibypass = 1'b0; ivalid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ivalid = 1'b0; oready = 1'b1;
        chk("rst2_ovalid", 64'(ovalid), 64'h0);
        chk_state("rst2_ostate", ostate, zero, 64);
        chk("rst2_iready", 64'(iready), 64'h1);
        v = rnd_state(64);
        send(v, 1'b0);
        wait_out(cnt);
        chk("rst2_latency", 64'(cnt), 64'd2);
        chk_state("rst2_data", ostate, theta_ref(v, 1'b0, 64), 64);
        idle(3);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha3_theta_stage.md
Name: sha3_theta_stage

Overview:
- Full Keccak theta step over one 25-lane state: column parity, theta elements, lane XOR.
- Lane width is parametrised for Keccak-f[25w] variants.
- Register pipeline of 1 or 2 stages with valid/ready flow control and a per-transaction bypass.
- Sits in the permutation round datapath ahead of rho/pi; it supersedes the elts-only block for all lane widths.

Parameters:
- STYLE, "basic", logic style; only "basic" is legal, any other value raises $error at elaboration.
- LANE_WIDTH, 64, lane width w; legal values 1, 2, 4, 8, 16, 32, 64, else $error.
- LATENCY, 2, pipeline registers between input and output; legal values 1 or 2, else $error.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- istate  input  25 x LANE_WIDTH  input state; lane index = x + 5*y, with x and y in 0..4.
- ibypass  input  1  when high, the transaction passes through unchanged (no theta).
- ivalid  input  1  input transaction valid.
- iready  output  1  stage can accept; a transfer occurs when ivalid && iready.
- ostate  output  25 x LANE_WIDTH  output state, same lane indexing.
- ovalid  output  1  output transaction valid.
- oready  input  1  downstream accepts; a transfer occurs when ovalid && oready.

Behaviour:
- Arithmetic, all mod 5 on x:
  - C[x] = XOR over y of istate[x+5y].
  - D[x] = C[x-1] ^ rol1(C[x+1]); rol1 rotates left by 1 within LANE_WIDTH bits, so the MSB wraps to bit 0.
  - ostate[x+5y] = istate[x+5y] ^ D[x]. If bypass was captured high, ostate = istate bit-exact.
- LATENCY=2 pipeline:
  - Stage 1 registers the state lanes, the 5 parities C, bypass and valid.
  - Stage 2 computes D and the XOR from the stage-1 registers and registers ostate, ovalid.
- LATENCY=1: a single register stage holds the full result, bypass already applied.
- Flow control, per stage k: the stage loads when !valid_k || ready_(k+1).
  - The last stage's downstream ready is oready.
  - iready = !valid_1 || (stage 1 advancing this cycle). A combinational ready path from oready to iready is permitted.
- Throughput: one transaction per cycle while oready is held high. Latency from input transfer to ovalid is LATENCY cycles.
- Ordering: strictly in order. No transaction is dropped or duplicated.
- Hold rule: while ovalid && !oready, ostate is held stable.
- Holding capacity under full backpressure is LATENCY transactions; after that, iready = 0.
- Simultaneous input and output transfer on a full pipe: both occur in the same cycle, and occupancy is unchanged.
- Reset (rst high at a clock edge):
  - All valid bits clear, iready = 1, ovalid = 0, ostate = all zeros, internal data registers = 0.
  - Takes effect on the first edge; in-flight transactions are discarded.
  - ivalid is ignored while rst is high.
- Data registers load only when their stage loads, so there is no spurious toggling on idle cycles.
- Bypass is captured with its transaction and travels with it. Mixed bypass and theta transactions back-to-back are legal.

Test Plan:
- All-zero istate, ibypass=0, LANE_WIDTH=64 -> ostate all zero, ovalid exactly LATENCY cycles after the transfer.
- LANE_WIDTH=64, istate[0]=0x1 and all other lanes 0 -> ostate[0]=0x1; lanes 1, 6, 11, 16, 21 = 0x1; lanes 4, 9, 14, 19, 24 = 0x2; all others 0.
- LANE_WIDTH=8, istate[0]=0x80, others 0 -> lane 0 = 0x80; lanes 1, 6, 11, 16, 21 = 0x80; lanes 4, 9, 14, 19, 24 = 0x01 (rotation wrap).
- Random state, ibypass=1 interleaved with ibypass=0 on consecutive cycles -> bypass outputs equal their inputs exactly; the others match a reference-model theta; order preserved.
- LATENCY=2, oready=0 for 6 cycles, ivalid=1 with 4 distinct states -> 2 accepted, then iready=0. When oready=1, outputs appear 1 per cycle in order, then the remaining 2 are accepted; none lost.
- 3 transactions in flight, rst pulsed for 1 cycle -> next cycle ovalid=0, ostate=0, iready=1. A new transaction afterwards emerges after LATENCY cycles with correct data.
